// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: radix-2 iterative engine, one bit per cycle,
// early finish for divide-by-zero / signed overflow, optional single-cycle multiply.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_zero,
    output logic            div_ovf
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     m_q, m_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [CW-1:0]       count_q, count_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                dz_q, dz_d;
    logic                ovf_q, ovf_d;

    // Operand decode on the raw inputs, only meaningful in the accept cycle.
    logic                a_sgn, b_sgn, a_neg, b_neg, dz_in, ovf_in, fast_in;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic [2*XLEN-1:0]   fast_prod;

    always_comb begin
        a_sgn   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_sgn   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg   = a_sgn && A[XLEN-1];
        b_neg   = b_sgn && B[XLEN-1];
        a_abs   = a_neg ? -A : A;
        b_abs   = b_neg ? -B : B;
        dz_in   = op[2] && (B == '0);
        ovf_in  = ((op == OP_DIV) || (op == OP_REM)) &&
                  (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
        fast_in = dz_in || ovf_in || (MUL_FAST && !op[2]);
    end

    generate
        if (MUL_FAST) begin : g_fast
            logic [2*XLEN-1:0] mag;
            assign mag       = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
            assign fast_prod = (a_neg ^ b_neg) ? -mag : mag;
        end else begin : g_slow
            assign fast_prod = '0;
        end
    endgenerate

    // acc holds {hi, lo}: product accumulator / multiplier for MUL*, remainder / quotient for DIV*.
    logic [XLEN:0]       mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0]   mul_step, div_step, prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
        div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod_fix = qneg_q ? -acc_q : acc_q;
        quo_fix  = qneg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = fast_in ? S_DONE : S_CALC;
            S_CALC: if (count_q == CW'(XLEN-1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        result    = result_q;
        div_zero  = dz_q;
        div_ovf   = ovf_q;
    end

    always_comb begin
        op_d     = op_q;
        m_d      = m_q;
        acc_d    = acc_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        count_d  = count_q;
        result_d = result_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    count_d = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    m_d     = op[2] ? b_abs : a_abs;
                    acc_d   = {{XLEN{1'b0}}, (op[2] ? a_abs : b_abs)};
                    dz_d    = dz_in;
                    ovf_d   = ovf_in;
                    if (dz_in)
                        result_d = op[1] ? A : '1;
                    else if (ovf_in)
                        result_d = op[1] ? '0 : A;
                    else if (fast_in)
                        result_d = (op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                end
            end
            S_CALC: begin
                count_d = count_q + CW'(1);
                acc_d   = op_q[2] ? div_step : mul_step;
            end
            S_FIX: begin
                if (op_q[2])
                    result_d = op_q[1] ? rem_fix : quo_fix;
                else
                    result_d = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            end
            default: ;
        endcase
        // A squash drops the flags but leaves the last result on the bus.
        if (flush) begin
            result_d = result_q;
            dz_d     = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            count_q  <= count_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: XLEN=32 iterative instance and XLEN=16 fast-multiply instance.
module tb_muldiv_unit;
    typedef struct {
        logic [31:0] res;
        logic        dz;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic [2:0]  opc;
    logic [31:0] opa, opb;
    logic        in_valid0, in_ready0, out_valid0, out_ready0, dz0, ovf0;
    logic [31:0] result0;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, dz1, ovf1;
    logic [15:0] result1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t cur0, cur1;
    bit   have0 = 0;
    bit   hold_req = 0;
    int   hold_left = 0;
    logic [31:0] last_exp0 = '0;

    muldiv_unit #(.XLEN(32), .MUL_FAST(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
        .op(opc), .A(opa), .B(opb), .out_valid(out_valid0), .out_ready(out_ready0),
        .result(result0), .div_zero(dz0), .div_ovf(ovf0)
    );

    muldiv_unit #(.XLEN(16), .MUL_FAST(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(opc), .A(opa[15:0]), .B(opb[15:0]), .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .div_zero(dz1), .div_ovf(ovf1)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on wide integers.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input int xl, output logic [31:0] res,
                                  output logic dz, output logic ovf);
        logic signed [127:0] sa, sb, msk, p, q, r;
        bit sga, sgb;
        msk = (128'sd1 <<< xl) - 128'sd1;
        sga = (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd6);
        sgb = (o == 3'd1) || (o == 3'd4) || (o == 3'd6);
        sa = '0;
        sb = '0;
        sa[31:0] = a;
        sb[31:0] = b;
        if (sga && a[xl-1]) sa = sa - (128'sd1 <<< xl);
        if (sgb && b[xl-1]) sb = sb - (128'sd1 <<< xl);
        dz  = o[2] && (sb == 0);
        ovf = o[2] && sgb && (sb == -128'sd1) && (sa == -(128'sd1 <<< (xl-1)));
        if (!o[2]) begin
            p   = sa * sb;
            res = 32'(((o == 3'd0) ? p : (p >>> xl)) & msk);
        end else begin
            if (dz) begin
                q = -128'sd1;
                r = sa;
            end else if (ovf) begin
                q = sa;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
            res = 32'((o[1] ? r : q) & msk);
        end
    endfunction

    task automatic issue(input bit sel, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic edz,
                         input logic eovf, input bit push);
        exp_t e;
        int   g = 0;
        bit   fast;
        @(negedge clk);
        while (!(sel ? in_ready1 : in_ready0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("in_ready_wait", 32'(sel ? in_ready1 : in_ready0), 32'd1);
        opc = o;
        opa = a;
        opb = b;
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        opa = $urandom;
        opb = $urandom;
        if (push) begin
            fast  = edz || eovf || (sel && !o[2]);
            e.res = er;
            e.dz  = edz;
            e.ovf = eovf;
            e.acc = cyc;
            e.lat = fast ? 0 : (sel ? 17 : 33);
            if (sel) q1.push_back(e);
            else begin
                q0.push_back(e);
                last_exp0 = er;
            end
        end
    endtask

    task automatic issue_m(input bit sel, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        dz, ovf;
        model(o, a, b, sel ? 16 : 32, r, dz, ovf);
        issue(sel, o, a, b, r, dz, ovf, 1'b1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_8000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drain();
        int g = 0;
        while ((q0.size() != 0 || q1.size() != 0 || have0 || !in_ready0) && g < 600) begin
            @(negedge clk);
            g++;
        end
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);
    endtask

    // Monitor for the 32-bit instance; also drives out_ready with random back-pressure.
    initial begin
        out_ready0 = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid0) begin
                if (!have0) begin
                    if (q0.size() == 0) begin
                        chk("unexpected_valid0", 32'd1, 32'd0);
                    end else begin
                        cur0  = q0.pop_front();
                        have0 = 1;
                        chk("result0", result0, cur0.res);
                        chk("div_zero0", 32'(dz0), 32'(cur0.dz));
                        chk("div_ovf0", 32'(ovf0), 32'(cur0.ovf));
                        chk("latency0", 32'(cyc - cur0.acc), 32'(cur0.lat));
                        if (hold_req) begin
                            hold_left = 5;
                            hold_req  = 0;
                        end
                    end
                end else begin
                    chk("held_result0", result0, cur0.res);
                    chk("held_in_ready0", 32'(in_ready0), 32'd0);
                end
                if (hold_left > 0) begin
                    out_ready0 = 1'b0;
                    hold_left--;
                end else begin
                    out_ready0 = ($urandom_range(0, 2) != 0);
                end
                if (out_ready0) have0 = 0;
            end else begin
                out_ready0 = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        out_ready1 = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_valid1", 32'd1, 32'd0);
                end else begin
                    cur1 = q1.pop_front();
                    chk("result1", {16'h0, result1}, cur1.res);
                    chk("div_zero1", 32'(dz1), 32'(cur1.dz));
                    chk("div_ovf1", 32'(ovf1), 32'(cur1.ovf));
                    chk("latency1", 32'(cyc - cur1.acc), 32'(cur1.lat));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        opc = '0;
        opa = '0;
        opb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_result", result0, 32'd0);
        chk("rst_div_zero", 32'(dz0), 32'd0);
        chk("rst_div_ovf", 32'(ovf0), 32'd0);
        rst_n = 1'b1;

        hold_req = 1;
        issue(0, 3'd5, 32'd100, 32'd7, 32'd14, 0, 0, 1);
        issue(0, 3'd7, 32'd100, 32'd7, 32'd2, 0, 0, 1);
        issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, 1);
        issue(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, 1);
        issue(0, 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 1);
        issue(0, 3'd6, 32'd5, 32'd0, 32'd5, 1, 0, 1);
        issue(0, 3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 0, 1);
        issue(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 1);
        issue(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, 1);
        issue(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0, 1);
        issue(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1);
        issue(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 1);
        issue(0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 1);
        drain();

        issue(0, 3'd5, 32'd1000, 32'd3, 32'd0, 0, 0, 0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready0), 32'd1);
        chk("flush_out_valid", 32'(out_valid0), 32'd0);
        chk("flush_result_kept", result0, last_exp0);

        opc = 3'd4;
        opa = 32'd5;
        opb = 32'd0;
        in_valid0 = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        flush = 1'b0;
        chk("flush_beats_accept_ready", 32'(in_ready0), 32'd1);
        chk("flush_beats_accept_valid", 32'(out_valid0), 32'd0);

        issue(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 0, 0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midop_rst_in_ready", 32'(in_ready0), 32'd1);
        chk("midop_rst_out_valid", 32'(out_valid0), 32'd0);
        chk("midop_rst_result", result0, 32'd0);

        for (int i = 0; i < 120; i++)
            issue_m(0, 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
        drain();

        issue(1, 3'd5, 32'd1000, 32'd3, 32'd333, 0, 0, 1);
        issue(1, 3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0001, 0, 0, 1);
        issue(1, 3'd3, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 0, 0, 1);
        issue(1, 3'd4, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 0, 1, 1);
        for (int i = 0; i < 40; i++)
            issue_m(1, 3'($urandom_range(0, 7)), rnd_opnd() & 32'hFFFF, rnd_opnd() & 32'hFFFF);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
